lsu_mem_stage: RTL
==================

// Module: lsu_mem_stage
// PURPOSE
//  Pipelined successor of the single-cycle MEM stage: sits between the EX/MEM and MEM/WB boundaries.
//  Drives a data-memory port with a req/gnt/rvalid handshake, so memory latency is variable.
//  Generates byte enables and replicated store data; aligns and sign/zero-extends load data.
//  Selects the writeback value (load data, PC+4, or ALU), flags misaligned accesses and stalls upstream while busy.
// PARAMETERS
//  XLEN       32   datapath width, 32 or 64; LD/SD/LWU legal only when XLEN=64
//  PC_INC     4    increment added to in_pc for JAL/JALR writeback
// PORTS
//  clk          in   1        rising-edge clock (single clock domain)
//  reset        in   1        asynchronous, active-high reset
//  flush        in   1        kill in-flight instruction (branch redirect / trap)
//  in_valid     in   1        EX/MEM holds a valid instruction
//  in_ready     out  1        stage accepts the instruction this cycle
//  in_pc        in   XLEN     instruction PC
//  in_inst      in   32       raw instruction word
//  in_alu       in   XLEN     ALU result / effective address
//  in_rs2       in   XLEN     store data
//  dmem_req     out  1        memory request valid
//  dmem_we      out  1        1 = store, 0 = load
//  dmem_addr    out  XLEN     byte address (in_alu, registered)
//  dmem_be      out  XLEN/8   byte-lane enables
//  dmem_wdata   out  XLEN     store data replicated across lanes
//  dmem_gnt     in   1        request accepted (store complete on gnt)
//  dmem_rvalid  in   1        load data valid
//  dmem_rdata   in   XLEN     raw load data, full lane width
//  wb_valid     out  1        MEM/WB register valid (one-cycle pulse per instruction)
//  wb_we        out  1        register-file write enable
//  wb_rd        out  5        destination register
//  wb_data      out  XLEN     writeback value
//  wb_misalign  out  1        misaligned load/store; no memory access performed
// BEHAVIOUR
//  Reset: async; state=IDLE; all outputs 0; drop flag cleared. Asserting reset mid-transaction abandons it.
//  Decode, opcode inst[6:0]:
//   - LOAD=0000011 and STORE=0100011 are memory ops.
//   - JAL=1101111 and JALR=1100111 write in_pc+PC_INC.
//   - All other opcodes write in_alu.
//  funct3 size: 000/100=B, 001/101=H, 010/110=W, 011=D. 100/101/110 zero-extend; the rest sign-extend.
//  wb_we = !STORE && !BRANCH(1100011) && rd!=0 && !misalign.
//  Lane = addr[log2(XLEN/8)-1:0]. dmem_be = size_mask << lane. Read data is shifted right by lane*8 before extension.
//  Misaligned when: H with addr[0]=1; W with addr[1:0]!=0; D with addr[2:0]!=0.
//   - No dmem_req is issued.
//   - Next cycle: wb_valid=1, wb_misalign=1, wb_we=0.
//  FSM:
//   - IDLE: in_ready=1. When in_valid && !flush:
//     - Non-memory op or misaligned op: register the wb outputs; wb_valid next cycle (latency 1); stay IDLE.
//     - Aligned memory op: latch address, be, wdata and rd; go to REQ.
//   - REQ: dmem_req=1 with request fields held stable until dmem_gnt.
//     - On gnt, store: wb_valid next cycle (wb_we=0); go to IDLE.
//     - On gnt, load: go to RSP.
//     - flush while in REQ: drop req the same cycle; go to IDLE; no wb.
//   - RSP: wait for dmem_rvalid.
//     - On rvalid: wb_valid next cycle with the extended data; go to IDLE.
//     - flush in RSP: set the drop flag, keep waiting; the rvalid is consumed with no wb_valid.
//   - in_ready=0 in REQ and RSP.
//  Boundary cases:
//   - gnt and rvalid in the same cycle in REQ: treat as gnt then rvalid; go straight to the wb cycle.
//   - rvalid while IDLE or REQ: ignored.
//   - flush together with in_valid in IDLE: instruction not accepted.
//   - Back-to-back non-memory instructions: one per cycle, with no bubble.
//   - wb_valid deasserts after one cycle. No downstream backpressure exists.
// STRUCTURE
//  Package lsu_pkg: opcode and funct3 localparams; size encodings; state encoding IDLE/REQ/RSP.
//  Sub-module lsu_align (combinational): size/lane in -> be, wdata, misalign; raw rdata -> extended load data.
//  Top-level body: FSM, request registers, MEM/WB output registers.
// TESTING
//  1. ADD, alu=0x1234, rd=5 -> wb_valid next cycle: wb_data=0x1234, wb_we=1, wb_rd=5. No dmem_req.
//  2. LB addr=0x103, rdata=0x80AABBCC, gnt and rvalid 2 cycles late -> dmem_be=4'b1000, wb_data=0xFFFFFF80.
//     Same case with LBU -> wb_data=0x00000080.
//  3. SH addr=0x102, rs2=0xDEADBEEF, gnt held low 3 cycles -> req held 4 cycles with be=4'b1100, wdata=0xBEEFBEEF.
//     Then wb_valid with wb_we=0; in_ready=0 throughout.
//  4. LW addr=0x101 -> no dmem_req; wb_misalign=1, wb_we=0 next cycle.
//  5. LW issued, flush in RSP, rvalid 2 cycles later -> no wb_valid; the next ADD completes normally.
//  6. Reset asserted in REQ -> dmem_req falls immediately (async); after release, state=IDLE and in_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared decode constants, access-size encodings and FSM states for the load/store MEM stage.
package lsu_pkg;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   // funct3[1:0] selects the size; funct3[2] selects zero-extension
   typedef enum logic [1:0] {
      SizeB = 2'd0,
      SizeH = 2'd1,
      SizeW = 2'd2,
      SizeD = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StRsp  = 2'd2
   } lsu_state_e;

   function automatic logic [7:0] size_mask(lsu_size_e size);
      logic [7:0] mask;
      case (size)
         SizeB:   mask = 8'h01;
         SizeH:   mask = 8'h03;
         SizeW:   mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and misalignment on the request
// side; lane shift and sign/zero extension of raw read data on the response side.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [1:0]                    req_size_i,
   input  logic [XLEN-1:0]               req_addr_i,
   input  logic [XLEN-1:0]               req_rs2_i,
   output logic [XLEN/8-1:0]             be_o,
   output logic [XLEN-1:0]               wdata_o,
   output logic                          misalign_o,
   input  logic [1:0]                    rsp_size_i,
   input  logic                          rsp_uns_i,
   input  logic [$clog2(XLEN/8)-1:0]     rsp_lane_i,
   input  logic [XLEN-1:0]               rdata_i,
   output logic [XLEN-1:0]               ld_data_o
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned LaneW = $clog2(NB);

   logic [LaneW-1:0] req_lane;
   logic [NB-1:0]    req_mask;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  keep;
   logic             sign;

   assign req_lane = req_addr_i[LaneW-1:0];
   assign req_mask = NB'(size_mask(lsu_size_e'(req_size_i)));
   assign be_o     = req_mask << req_lane;

   always_comb begin
      wdata_o    = req_rs2_i;
      misalign_o = 1'b0;
      case (lsu_size_e'(req_size_i))
         SizeB: begin
            wdata_o = {NB{req_rs2_i[7:0]}};
         end
         SizeH: begin
            wdata_o    = {(NB/2){req_rs2_i[15:0]}};
            misalign_o = req_addr_i[0];
         end
         SizeW: begin
            wdata_o    = {(NB/4){req_rs2_i[31:0]}};
            misalign_o = |req_addr_i[1:0];
         end
         default: begin
            // A 32-bit datapath has no doubleword lanes, so D is never performed there
            misalign_o = (XLEN < 64) || (|req_addr_i[2:0]);
         end
      endcase
   end

   assign shifted = rdata_i >> {rsp_lane_i, 3'b000};

   always_comb begin
      keep = '1;
      sign = shifted[XLEN-1];
      case (lsu_size_e'(rsp_size_i))
         SizeB: begin
            keep = XLEN'(8'hFF);
            sign = shifted[7];
         end
         SizeH: begin
            keep = XLEN'(16'hFFFF);
            sign = shifted[15];
         end
         SizeW: begin
            keep = XLEN'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: ;
      endcase
      ld_data_o = (shifted & keep) | ({XLEN{sign & ~rsp_uns_i}} & ~keep);
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Pipelined MEM stage: issues one data-memory transaction at a time over req/gnt/rvalid,
// and produces a single-cycle MEM/WB pulse per accepted instruction.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PC_INC = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [31:0]         in_inst,
   input  logic [XLEN-1:0]     in_alu,
   input  logic [XLEN-1:0]     in_rs2,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [XLEN-1:0]     dmem_addr,
   output logic [XLEN/8-1:0]   dmem_be,
   output logic [XLEN-1:0]     dmem_wdata,
   input  logic                dmem_gnt,
   input  logic                dmem_rvalid,
   input  logic [XLEN-1:0]     dmem_rdata,
   output logic                wb_valid,
   output logic                wb_we,
   output logic [4:0]          wb_rd,
   output logic [XLEN-1:0]     wb_data,
   output logic                wb_misalign
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned LaneW = $clog2(NB);

   lsu_state_e state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [NB-1:0]   be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q, we_d;
   logic [4:0]      rd_q, rd_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic            drop_q, drop_d;
   logic            wb_valid_q, wb_valid_d;
   logic            wb_we_q, wb_we_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            wb_misalign_q, wb_misalign_d;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic            is_load, is_store, is_mem, is_link, is_branch, misalign;
   logic [NB-1:0]   req_be;
   logic [XLEN-1:0] req_wdata;
   logic            req_mis;
   logic [XLEN-1:0] ld_data;

   assign opcode    = in_inst[6:0];
   assign funct3    = in_inst[14:12];
   assign rd        = in_inst[11:7];
   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_mem    = is_load | is_store;
   assign is_link   = (opcode == OpJal) | (opcode == OpJalr);
   assign is_branch = (opcode == OpBranch);
   assign misalign  = is_mem & req_mis;

   lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .req_size_i (funct3[1:0]),
      .req_addr_i (in_alu),
      .req_rs2_i  (in_rs2),
      .be_o       (req_be),
      .wdata_o    (req_wdata),
      .misalign_o (req_mis),
      .rsp_size_i (size_q),
      .rsp_uns_i  (uns_q),
      .rsp_lane_i (addr_q[LaneW-1:0]),
      .rdata_i    (dmem_rdata),
      .ld_data_o  (ld_data)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      rd_d          = rd_q;
      size_d        = size_q;
      uns_d         = uns_q;
      drop_d        = drop_q;
      wb_valid_d    = 1'b0;
      wb_we_d       = wb_we_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      wb_misalign_d = wb_misalign_q;

      case (state_q)
         StIdle: begin
            if (in_valid && !flush) begin
               if (is_mem && !misalign) begin
                  addr_d  = in_alu;
                  be_d    = req_be;
                  wdata_d = req_wdata;
                  we_d    = is_store;
                  rd_d    = rd;
                  size_d  = funct3[1:0];
                  uns_d   = funct3[2];
                  state_d = StReq;
               end else begin
                  wb_valid_d    = 1'b1;
                  wb_we_d       = !is_store && !is_branch && (rd != 5'd0) && !misalign;
                  wb_rd_d       = rd;
                  wb_data_d     = is_link ? in_pc + XLEN'(PC_INC) : in_alu;
                  wb_misalign_d = misalign;
               end
            end
         end
         StReq: begin
            if (flush) begin
               state_d = StIdle;
            end else if (dmem_gnt) begin
               if (we_q) begin
                  wb_valid_d    = 1'b1;
                  wb_we_d       = 1'b0;
                  wb_rd_d       = rd_q;
                  wb_data_d     = addr_q;
                  wb_misalign_d = 1'b0;
                  state_d       = StIdle;
               end else if (dmem_rvalid) begin
                  wb_valid_d    = 1'b1;
                  wb_we_d       = (rd_q != 5'd0);
                  wb_rd_d       = rd_q;
                  wb_data_d     = ld_data;
                  wb_misalign_d = 1'b0;
                  state_d       = StIdle;
               end else begin
                  state_d = StRsp;
               end
            end
         end
         StRsp: begin
            // A flushed load still has data in flight; absorb it silently
            if (flush) begin
               drop_d = 1'b1;
            end
            if (dmem_rvalid) begin
               if (!drop_q && !flush) begin
                  wb_valid_d    = 1'b1;
                  wb_we_d       = (rd_q != 5'd0);
                  wb_rd_d       = rd_q;
                  wb_data_d     = ld_data;
                  wb_misalign_d = 1'b0;
               end
               drop_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
         we_q          <= 1'b0;
         rd_q          <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         drop_q        <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_we_q       <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         wb_misalign_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         be_q          <= be_d;
         wdata_q       <= wdata_d;
         we_q          <= we_d;
         rd_q          <= rd_d;
         size_q        <= size_d;
         uns_q         <= uns_d;
         drop_q        <= drop_d;
         wb_valid_q    <= wb_valid_d;
         wb_we_q       <= wb_we_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         wb_misalign_q <= wb_misalign_d;
      end
   end

   // Request is withdrawn combinationally on flush so memory never grants a killed access
   assign dmem_req    = (state_q == StReq) && !flush;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_be     = be_q;
   assign dmem_wdata  = wdata_q;
   assign in_ready    = (state_q == StIdle) && !reset;
   assign wb_valid    = wb_valid_q;
   assign wb_we       = wb_we_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign wb_misalign = wb_misalign_q;

endmodule
